// File: rtl/led_toggle_multi.sv
`timescale 1ns/1ps
// led_toggle_multi
//
// Drives NUM_CHANNELS LEDs from the same number of active-low push buttons.
// Each button is synchronized, then debounced. A debounced press (a 1->0 change)
// produces a one-cycle strobe and flips a per-channel toggle bit. A global
// 2-bit mode selects how each LED is driven:
//   0 toggle    : LED shows the toggle bit
//   1 momentary : LED is lit while the debounced button is held
//   2 blink     : toggle bit gated by a shared blink phase
//   3 off       : all LEDs dark; presses still flip the toggle bits
//
// Ports
//   clock        system clock; all logic runs on its rising edge
//   reset_n      asynchronous active-low reset; its release is synchronized internally
//   buttons_n    raw active-low buttons, one per channel
//   mode         raw global mode select, synchronized like the buttons
//   leds         registered LED drive, 1 = lit
//   press_pulse  one-cycle strobe per accepted press, one per channel
module led_toggle_multi #(
  parameter int unsigned NUM_CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned BLINK_HALF_PERIOD = 12500000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_CHANNELS-1:0] buttons_n,
  input  logic [1:0]              mode,
  output logic [NUM_CHANNELS-1:0] leds,
  output logic [NUM_CHANNELS-1:0] press_pulse
);

  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BlinkW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;

  // Counter value at which a differing sample is accepted as the new level.
  localparam logic [CntW-1:0]   CntAccept = CntW'(DEBOUNCE_CYCLES);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    ModeToggle    = 2'd0,
    ModeMomentary = 2'd1,
    ModeBlink     = 2'd2,
    ModeOff       = 2'd3
  } mode_e;

  // ---------------------------------------------------------------------------
  // Reset synchronizer: asserts asynchronously, releases two clocks after
  // reset_n rises. Everything else is reset from rst_n.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Input synchronizers. Buttons idle high (released), mode idles at toggle.
  // ---------------------------------------------------------------------------
  logic [NUM_CHANNELS-1:0] btn_sync_q  [SYNC_STAGES];
  logic [1:0]              mode_sync_q [SYNC_STAGES];
  logic [NUM_CHANNELS-1:0] btn_s;
  mode_e                   mode_s;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        btn_sync_q[s]  <= '1;
        mode_sync_q[s] <= 2'b00;
      end
    end else begin
      btn_sync_q[0]  <= buttons_n;
      mode_sync_q[0] <= mode;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        btn_sync_q[s]  <= btn_sync_q[s-1];
        mode_sync_q[s] <= mode_sync_q[s-1];
      end
    end
  end

  assign btn_s  = btn_sync_q[SYNC_STAGES-1];
  assign mode_s = mode_e'(mode_sync_q[SYNC_STAGES-1]);

  // ---------------------------------------------------------------------------
  // Per-channel debounce. A channel's level only moves after DEBOUNCE_CYCLES
  // consecutive samples disagree with it; any agreeing sample restarts the run.
  // ---------------------------------------------------------------------------
  logic [NUM_CHANNELS-1:0] level_q, level_d;
  logic [CntW-1:0]         cnt_q [NUM_CHANNELS];
  logic [CntW-1:0]         cnt_d [NUM_CHANNELS];

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (btn_s[i] != level_q[i]) begin
        if ((cnt_q[i] + CntW'(1)) == CntAccept) begin
          level_d[i] = btn_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Press strobe and toggle state. The strobe is high in the cycle the
  // debounced level is newly low; the toggle bit flips on the following edge.
  // ---------------------------------------------------------------------------
  logic [NUM_CHANNELS-1:0] press_q, press_d;
  logic [NUM_CHANNELS-1:0] toggle_q, toggle_d;

  always_comb begin
    press_d  = level_q & ~level_d;
    toggle_d = toggle_q ^ press_q;
  end

  // ---------------------------------------------------------------------------
  // Shared free-running blink timer; phase flips each time the counter wraps.
  // ---------------------------------------------------------------------------
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BlinkW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // ---------------------------------------------------------------------------
  // LED mapping, registered from the current state and synchronized mode.
  // ---------------------------------------------------------------------------
  logic [NUM_CHANNELS-1:0] leds_q, leds_d;

  always_comb begin
    leds_d = '0;
    case (mode_s)
      ModeToggle:    leds_d = toggle_q;
      ModeMomentary: leds_d = ~level_q;
      ModeBlink:     leds_d = toggle_q & {NUM_CHANNELS{phase_q}};
      ModeOff:       leds_d = '0;
      default:       leds_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= '1;
      press_q     <= '0;
      toggle_q    <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      leds_q      <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q     <= level_d;
      press_q     <= press_d;
      toggle_q    <= toggle_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      leds_q      <= leds_d;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign leds        = leds_q;
  assign press_pulse = press_q;

endmodule

// File: tb/tb_led_toggle_multi.sv
`timescale 1ns/1ps
// Testbench for led_toggle_multi with small debounce/blink parameters.
// A cycle-level reference model pushes the expected outputs after every
// rising edge; a monitor on the falling edge pops and compares them.
module tb_led_toggle_multi;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int HP   = 8;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [NCH-1:0] buttons_n;
  logic [1:0]     mode;
  logic [NCH-1:0] leds;
  logic [NCH-1:0] press_pulse;

  led_toggle_multi #(
    .NUM_CHANNELS     (NCH),
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYCLES  (DB),
    .BLINK_HALF_PERIOD(HP)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .buttons_n  (buttons_n),
    .mode       (mode),
    .leds       (leds),
    .press_pulse(press_pulse)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [NCH-1:0] leds;
    logic [NCH-1:0] pulse;
  } exp_t;

  exp_t         exp_q[$];
  bit [NCH-1:0] btn_pipe[$];   // raw button samples still in flight to the debouncer
  bit [1:0]     mode_pipe[$];
  int           rel_edges;     // edges seen since reset_n rose
  int           active_edges;  // edges on which the block has been running
  bit [NCH-1:0] m_level, m_pulse, m_toggle, m_leds;
  int           run_len[NCH];  // consecutive samples disagreeing with the level

  function automatic void model_reset();
    rel_edges    = 0;
    active_edges = 0;
    m_level      = '1;
    m_pulse      = '0;
    m_toggle     = '0;
    m_leds       = '0;
    for (int c = 0; c < NCH; c++) run_len[c] = 0;
    btn_pipe.delete();
    mode_pipe.delete();
    for (int s = 0; s < SYNC; s++) begin
      btn_pipe.push_back('1);
      mode_pipe.push_back(2'd0);
    end
  endfunction

  function automatic void model_edge();
    bit [NCH-1:0] samp, new_level, new_leds;
    bit [1:0]     ms;
    bit           phase;
    if (!reset_n) begin
      model_reset();
    end else if (rel_edges < 2) begin
      rel_edges++;
    end else begin
      samp = btn_pipe.pop_front();
      ms   = mode_pipe.pop_front();
      btn_pipe.push_back(buttons_n);
      mode_pipe.push_back(mode);
      phase = ((active_edges / HP) % 2) == 1;
      case (ms)
        2'd0:    new_leds = m_toggle;
        2'd1:    new_leds = ~m_level;
        2'd2:    new_leds = phase ? m_toggle : '0;
        default: new_leds = '0;
      endcase
      new_level = m_level;
      for (int c = 0; c < NCH; c++) begin
        if (samp[c] == m_level[c]) begin
          run_len[c] = 0;
        end else begin
          run_len[c]++;
          if (run_len[c] == DB) begin
            new_level[c] = samp[c];
            run_len[c]   = 0;
          end
        end
      end
      m_toggle = m_toggle ^ m_pulse;
      m_pulse  = m_level & ~new_level;
      m_level  = new_level;
      m_leds   = new_leds;
      active_edges++;
    end
    exp_q.push_back(exp_t'({m_leds, m_pulse}));
  endfunction

  always @(posedge clock) model_edge();

  // Asynchronous reset clears outputs before the next falling-edge sample.
  always @(negedge reset_n) begin
    model_reset();
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      exp_q.push_back('0);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int pulse_cnt[NCH];
  int all_cnt = 0;

  initial for (int c = 0; c < NCH; c++) pulse_cnt[c] = 0;

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_underflow: no expected entry at t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("sb_leds", leds, e.leds);
      check("sb_press_pulse", press_pulse, e.pulse);
    end
    for (int c = 0; c < NCH; c++) if (press_pulse[c] === 1'b1) pulse_cnt[c]++;
    if (press_pulse === 4'b1111) all_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input int ch, input int len);
    buttons_n[ch] = 1'b0;
    tick(len);
    buttons_n[ch] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nt, last, bad, lows;
    int hold[NCH];
    logic prev;

    model_reset();
    reset_n   = 1'b1;
    buttons_n = '1;
    mode      = 2'd0;
    #2 reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(6);
    check("reset_leds", leds, 4'b0000);
    check("reset_pulse", press_pulse, 4'b0000);

    // Toggle mode: long press lights, second press clears.
    press(0, 20);
    tick(10);
    check("a_pulse_cnt0", pulse_cnt[0], 1);
    check("a_leds_on", leds, 4'b0001);
    press(0, 20);
    tick(10);
    check("a_pulse_cnt0_second", pulse_cnt[0], 2);
    check("a_leds_off", leds, 4'b0000);

    // Glitch one cycle short of the debounce interval, then exactly long enough.
    press(1, DB - 1);
    tick(10);
    check("b_glitch_pulse_cnt1", pulse_cnt[1], 0);
    check("b_glitch_leds", leds, 4'b0000);
    press(1, DB);
    tick(10);
    check("b_press_pulse_cnt1", pulse_cnt[1], 1);
    check("b_press_leds", leds, 4'b0010);

    // Momentary mode and release latency.
    mode = 2'd1;
    tick(6);
    check("c_mom_idle", leds, 4'b0000);
    buttons_n[2] = 1'b0;
    tick(10);
    check("c_mom_held", leds, 4'b0100);
    buttons_n[2] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (leds[2] === 1'b0) begin
        lat = k;
        break;
      end
    end
    check("c_release_latency", lat, DB + SYNC + 1);
    check("c_pulse_cnt2", pulse_cnt[2], 1);
    mode = 2'd0;
    tick(6);
    check("c_toggle_leds", leds, 4'b0110);

    // Blink mode: 8 high / 8 low, then steady in toggle mode.
    press(3, 6);
    tick(10);
    check("d_leds_before_blink", leds, 4'b1110);
    mode = 2'd2;
    nt   = 0;
    last = 0;
    bad  = 0;
    prev = leds[3];
    for (int k = 1; k <= 48; k++) begin
      tick(1);
      if (leds[3] !== prev) begin
        if (nt >= 2 && (k - last) != HP) bad++;
        nt++;
        last = k;
        prev = leds[3];
      end
    end
    check("d_blink_bad_intervals", bad, 0);
    check("d_blink_enough_edges", (nt >= 5), 1'b1);
    mode = 2'd0;
    tick(4);
    lows = 0;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      if (leds[3] !== 1'b1) lows++;
    end
    check("d_steady_after_blink", lows, 0);

    // All channels pressed together.
    buttons_n = '0;
    tick(6);
    buttons_n = '1;
    tick(10);
    check("e_all_pulse_cnt", all_cnt, 1);
    check("e_leds", leds, 4'b0001);

    // Reset in the middle of a debounce with the button kept held.
    buttons_n[0] = 1'b0;
    tick(4);
    reset_n = 1'b0;
    #1;
    check("g_reset_leds_now", leds, 4'b0000);
    check("g_reset_pulse_now", press_pulse, 4'b0000);
    tick(3);
    reset_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (press_pulse[0] === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("g_pulse_after_reset", lat, 2 + SYNC + DB);
    buttons_n[0] = 1'b1;
    tick(10);
    check("g_leds_after", leds, 4'b0001);

    // Randomized buttons and modes against the model.
    for (int c = 0; c < NCH; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        if (hold[c] == 0) begin
          buttons_n[c] = 1'($urandom_range(0, 1));
          hold[c]      = $urandom_range(1, 8);
        end
        hold[c]--;
      end
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      tick(1);
    end
    buttons_n = '1;
    mode      = 2'd0;
    tick(12);
    check("sb_depth", exp_q.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_toggle_multi.md
LED_TOGGLE_MULTI -- requirements
Module: led_toggle_multi

Interface
REQ-001 The block SHALL have parameter NUM_CHANNELS, default 4, the number of independent button/LED channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the flip-flop stages per input synchronizer (>=2).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, the consecutive stable clock cycles required to accept a level change (10 ms at 50 MHz, >=1).
REQ-004 The block SHALL have parameter BLINK_HALF_PERIOD, default 12500000, the clock cycles per blink half-period (>=1).
REQ-005 The block SHALL have port clock, input, 1 bit: 50 MHz system clock, all logic on rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port buttons_n, input, NUM_CHANNELS bits: asynchronous active-low push buttons, bit i drives channel i.
REQ-008 The block SHALL have port mode, input, 2 bits: global mode; 0 = toggle, 1 = momentary, 2 = blink, 3 = all off; synchronized internally like the buttons.
REQ-009 The block SHALL have port leds, output, NUM_CHANNELS bits: registered LED drive, 1 = lit.
REQ-010 The block SHALL have port press_pulse, output, NUM_CHANNELS bits: one-cycle strobe per accepted press (debounced falling edge).

Function
REQ-011 Each buttons_n bit and each mode bit SHALL pass through a SYNC_STAGES flip-flop chain before any other use; no raw pin feeds logic.
REQ-012 Each channel SHALL hold a debounced level (reset 1) and a counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits (reset 0).
REQ-013 Debounce: synchronized sample equal to debounced level -> counter cleared; differing -> counter increments; on the cycle the counter would reach DEBOUNCE_CYCLES, the debounced level takes the sample and the counter clears.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the debounced level and SHALL NOT emit press_pulse.
REQ-015 press_pulse[i] SHALL be 1 for exactly the one cycle after debounced level i changes 1->0; releases (0->1) SHALL emit nothing.
REQ-016 Each channel SHALL hold a toggle state bit (reset 0) that inverts on every press_pulse[i], in every mode including 3.
REQ-017 A single shared blink counter 0..BLINK_HALF_PERIOD-1 SHALL run freely; on wrap to 0 the blink phase bit (reset 0) inverts.
REQ-018 leds[i] SHALL be registered, one cycle after its inputs: mode 0 -> toggle[i]; mode 1 -> NOT debounced level[i]; mode 2 -> toggle[i] AND blink phase; mode 3 -> 0.
REQ-019 Mode changes SHALL NOT alter toggle state or the blink counter; leds follow the new mapping one cycle after the synchronized mode changes.
REQ-020 Simultaneous presses on several channels SHALL be handled independently in the same cycle; channels SHALL share no state except the blink counter, phase and mode.

Reset
REQ-021 reset_n low SHALL asynchronously force leds=0, press_pulse=0, all toggle bits 0, debounced levels 1, debounce counters 0, blink counter 0, phase 0, synchronizer flops to idle (buttons 1, mode 0).
REQ-022 Deassertion SHALL be synchronized internally through a 2-stage reset synchronizer (asynchronous assert, synchronous release); the block is idle for 2 cycles after reset_n rises.
REQ-023 Reset during a debounce count or mid-press SHALL discard it; a button still held after release of reset SHALL produce one press_pulse after a full debounce interval.

Verification (bench: NUM_CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, BLINK_HALF_PERIOD=8)
REQ-024 Mode 0, buttons_n[0] held low 20 cycles -> exactly one press_pulse[0], leds=4'b0001; second identical press -> leds=4'b0000.
REQ-025 buttons_n[1] low for 3 cycles, then high -> no press_pulse, leds unchanged; low for 4+ cycles -> one press_pulse[1].
REQ-026 Mode 1, buttons_n[2] held low 10 cycles -> leds[2]=1 while debounced-low, returns 0 DEBOUNCE_CYCLES+SYNC_STAGES+1 cycles after release; toggle[2] inverted once.
REQ-027 Mode 2 after toggling channel 3 on -> leds[3] alternates 8 cycles high, 8 cycles low; switching to mode 0 -> leds[3] steady 1.
REQ-028 buttons_n=4'b0000 pressed together -> press_pulse=4'b1111 in the same cycle; reset_n pulsed low mid-debounce -> leds=0 immediately, no pulse until a full debounce after reset release.
